// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg: shared widths, FSM encoding, reset level.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_pend_buf.sv
// ---------------------------------------------------------------------------
// wb_pend_buf: one-entry pending result buffer with x0 drop and kill.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_pend_buf
  import wb_port_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              grant,
  input  logic              kill,
  output logic              lu_ready,
  output logic              load,
  output logic              valid,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign lu_ready = !valid_q;
  // A handshake to x0 completes but never occupies the buffer.
  assign load     = lu_valid && !valid_q && (lu_waddr != '0);

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (load) begin
      valid_d = 1'b1;
      waddr_d = lu_waddr;
      wdata_d = lu_wdata;
    end else if (grant || kill) begin
      valid_d = 1'b0;
      waddr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      valid_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign valid = valid_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter: register-file write port shared by pipeline and a
// long-latency source, with anti-starvation stall request.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_waddr
);

  localparam logic [CNT_W-1:0] C_LIMIT = 4'(STARVE_LIMIT);

  logic              buf_valid, buf_load, buf_grant, buf_kill;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;
  logic              pipe_eff, lose;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              stall_req_q, stall_req_d;

  wb_pend_buf u_pend_buf (
    .clock    (clock),
    .reset    (reset),
    .lu_valid (lu_valid),
    .lu_waddr (lu_waddr),
    .lu_wdata (lu_wdata),
    .grant    (buf_grant),
    .kill     (buf_kill),
    .lu_ready (lu_ready),
    .load     (buf_load),
    .valid    (buf_valid),
    .waddr    (buf_waddr),
    .wdata    (buf_wdata)
  );

  assign pipe_eff  = pipe_we && (pipe_waddr != '0);
  assign buf_grant = buf_valid && !pipe_eff;
  // The younger pipeline write to the same register supersedes the pending one.
  assign buf_kill  = buf_valid && pipe_eff && (pipe_waddr == buf_waddr);
  assign lose      = buf_valid && pipe_eff && !buf_kill;

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_eff) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (buf_valid) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = buf_waddr;
      rf_wdata_d = buf_wdata;
    end

    if (!lose)
      wait_cnt_d = '0;
    else if (wait_cnt_q == C_LIMIT)
      wait_cnt_d = wait_cnt_q;
    else
      wait_cnt_d = wait_cnt_q + 4'd1;

    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (buf_load) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!lose)                        state_d = ST_EMPTY;
        else if (wait_cnt_d == C_LIMIT)   state_d = ST_STALL;
      end
      ST_STALL: if (!lose) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    stall_req_d = (state_d == ST_STALL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      state_q     <= ST_EMPTY;
      wait_cnt_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_req_q <= stall_req_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign stall_req  = stall_req_q;
  assign pend_valid = buf_valid;
  assign pend_waddr = buf_waddr;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter: directed vector table, corner sequences, random vs model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_waddr = '0;
  logic [31:0] lu_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        pend_valid;
  logic [4:0]  pend_waddr;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req),
    .pend_valid (pend_valid),
    .pend_waddr (pend_waddr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic        pv;
    logic [4:0]  pad;
    logic        rdy;
  } vec_t;

  vec_t tbl[16];

  // Reference model: a pending slot plus a count of cycles it has lost.
  bit          m_pend;
  bit [4:0]    m_pa;
  bit [31:0]   m_pd;
  int          m_lost;
  bit          m_we;
  bit [4:0]    m_wa;
  bit [31:0]   m_wd;
  bit          m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic st, input logic pv,
                            input logic [4:0] pa, input logic rdy);
    chk({tag, " rf_we"}, 32'(rf_we), 32'(we));
    if (we) begin
      chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(wa));
      chk({tag, " rf_wdata"}, rf_wdata, wd);
    end
    chk({tag, " stall_req"}, 32'(stall_req), 32'(st));
    chk({tag, " pend_valid"}, 32'(pend_valid), 32'(pv));
    chk({tag, " pend_waddr"}, 32'(pend_waddr), 32'(pa));
    chk({tag, " lu_ready"}, 32'(lu_ready), 32'(rdy));
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_pend = 0; m_pa = '0; m_pd = '0; m_lost = 0;
    m_we = 0; m_wa = '0; m_wd = '0; m_stall = 0;
  endtask

  task automatic model_step();
    bit eff, acc;
    if (!reset) begin
      model_clear();
      return;
    end
    eff = pipe_we && (pipe_waddr != 0);
    acc = lu_valid && !m_pend;
    if (eff) begin
      m_we = 1; m_wa = pipe_waddr; m_wd = pipe_wdata;
      if (m_pend) begin
        if (pipe_waddr == m_pa) m_pend = 0;
        else                    m_lost++;
      end
    end else if (m_pend) begin
      m_we = 1; m_wa = m_pa; m_wd = m_pd; m_pend = 0;
    end else begin
      m_we = 0;
    end
    if (acc && lu_waddr != 0) begin
      m_pend = 1; m_pa = lu_waddr; m_pd = lu_wdata; m_lost = 0;
    end
    if (!m_pend) m_lost = 0;
    m_stall = m_pend && (m_lost >= LIMIT);
  endtask

  initial begin
    // pipe_we pa pd | lu_valid la ld | we wa wd st pv pad rdy
    tbl[0]  = '{1'b1, 5'd8,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h1234,     1'b0, 1'b0, 5'd0,  1'b1};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd3,  1'b0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  1'b1};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'hAAAA,     1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd7,  1'b0};
    tbl[5]  = '{1'b1, 5'd7,  32'h55,       1'b1, 5'd2,  32'h2222,     1'b1, 5'd7,  32'h55,       1'b0, 1'b0, 5'd0,  1'b1};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};
    tbl[10] = '{1'b1, 5'd0,  32'h77,       1'b1, 5'd4,  32'h44,       1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd4,  1'b0};
    tbl[11] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44,       1'b0, 1'b0, 5'd0,  1'b1};
    tbl[12] = '{1'b1, 5'd10, 32'h1010,     1'b1, 5'd10, 32'h2020,     1'b1, 5'd10, 32'h1010,     1'b0, 1'b1, 5'd10, 1'b0};
    tbl[13] = '{1'b1, 5'd11, 32'h1111,     1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h1111,     1'b0, 1'b1, 5'd10, 1'b0};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h2020,     1'b0, 1'b0, 5'd0,  1'b1};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b1};

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
      chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);
      check_outs("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    end
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].lv, tbl[i].la, tbl[i].ld);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
                 tbl[i].st, tbl[i].pv, tbl[i].pad, tbl[i].rdy);
    end

    // Starvation: pending x5 loses to pipeline x9 until stall asserts.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5555);
    tick();
    check_outs("starve accept", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0);
    for (int i = 1; i <= LIMIT + 1; i++) begin
      drive(1'b1, 5'd9, 32'(i), 1'b0, 5'd0, 32'h0);
      tick();
      check_outs($sformatf("starve lost%0d", i), 1'b1, 5'd9, 32'(i),
                 (i >= LIMIT) ? 1'b1 : 1'b0, 1'b1, 5'd5, 1'b0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check_outs("starve grant", 1'b1, 5'd5, 32'h5555, 1'b0, 1'b0, 5'd0, 1'b1);

    // Reset pulse while in STALL.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6666);
    tick();
    for (int i = 0; i < LIMIT; i++) begin
      drive(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0);
      tick();
    end
    chk("pre-reset stall_req", 32'(stall_req), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("async stall_req", 32'(stall_req), 32'd0);
    chk("async pend_valid", 32'(pend_valid), 32'd0);
    chk("async rf_we", 32'(rf_we), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("post-reset%0d", i), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    end

    // Randomised traffic against the model; small address space forces WAW hits.
    model_clear();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) != 0);
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      model_step();
      tick();
      check_outs($sformatf("rnd%0d", i), m_we, m_wa, m_wd, m_stall,
                 m_pend, m_pend ? m_pa : 5'd0, !m_pend);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
